// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/miss/over sequencing, ball motion with
// wall, top/bottom and paddle bounces, scoring, lives and ball pixel overlay.
module pong_game_ctrl #(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int X_WALL_R  = 39,
    parameter int X_PAD_L   = 600,
    parameter int X_PAD_R   = 603,
    parameter int PAD_H     = 72,
    parameter int LIVES     = 3,
    parameter int SERVE_FR  = 60
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic [9:0] y_pad_t,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_on,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [9:0] SZ_M1      = 10'(BALL_SIZE - 1);
    localparam logic [9:0] STEP       = 10'(BALL_V);
    localparam logic [9:0] X_CENTER   = 10'((X_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTER   = 10'((Y_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0] Y_BOT_LIM  = 10'(Y_MAX - BALL_V);
    localparam logic [9:0] X_WALL_LIM = 10'(X_WALL_R + BALL_V);
    localparam logic [9:0] X_PAD_NEAR = 10'(X_PAD_L - BALL_V);
    localparam logic [9:0] X_PAD_FAR  = 10'(X_PAD_R);
    localparam logic [9:0] PAD_H_M1   = 10'(PAD_H - 1);
    localparam int         CNT_W      = $clog2(SERVE_FR + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FR - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_t           state_q,     state_d;
    logic [9:0]       ball_x_q,    ball_x_d;
    logic [9:0]       ball_y_q,    ball_y_d;
    logic             dx_q,        dx_d;      // 1 = moving right
    logic             dy_q,        dy_d;      // 1 = moving down
    logic             serve_dy_q,  serve_dy_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       score_q,     score_d;
    logic [1:0]       lives_q,     lives_d;
    logic             game_over_q, game_over_d;

    logic       frame_tick_s;
    logic [9:0] right_edge_s;
    logic [9:0] bottom_edge_s;
    logic [9:0] pad_bot_s;
    logic       hit_top_s;
    logic       hit_bot_s;
    logic       hit_wall_s;
    logic       hit_pad_s;
    logic       miss_s;
    logic       dx_new_s;
    logic       dy_new_s;
    logic       visible_s;

    // All comparisons keep the constants on the add side so nothing underflows.
    assign frame_tick_s  = (y_pixel == 10'd481) && (x_pixel == 10'd0);
    assign right_edge_s  = ball_x_q + SZ_M1;
    assign bottom_edge_s = ball_y_q + SZ_M1;
    assign pad_bot_s     = y_pad_t + PAD_H_M1;
    assign hit_top_s     = (ball_y_q <= STEP);
    assign hit_bot_s     = (bottom_edge_s >= Y_BOT_LIM);
    assign hit_wall_s    = (ball_x_q <= X_WALL_LIM);
    assign hit_pad_s     = dx_q
                        && (right_edge_s >= X_PAD_NEAR)
                        && (right_edge_s <= X_PAD_FAR)
                        && (bottom_edge_s >= y_pad_t)
                        && (ball_y_q <= pad_bot_s);
    assign miss_s        = (right_edge_s > X_PAD_FAR) && !hit_pad_s;
    assign dx_new_s      = hit_pad_s ? 1'b0 : (hit_wall_s ? 1'b1 : dx_q);
    assign dy_new_s      = hit_top_s ? 1'b1 : (hit_bot_s ? 1'b0 : dy_q);

    assign visible_s = (state_q == S_SERVE) || (state_q == S_PLAY);
    assign ball_on   = visible_s
                    && (x_pixel >= ball_x_q) && (x_pixel <= right_edge_s)
                    && (y_pixel >= ball_y_q) && (y_pixel <= bottom_edge_s);

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign state     = state_q;

    // Next-state and next-datapath computation for the game FSM.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_dy_d  = serve_dy_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_SERVE;
                    score_d     = 8'd0;
                    lives_d     = LIVES_INIT;
                    game_over_d = 1'b0;
                    cnt_d       = '0;
                    serve_dy_d  = 1'b1;
                    ball_x_d    = X_CENTER;
                    ball_y_d    = Y_CENTER;
                end else begin
                    state_d = state_q;
                end
            end
            S_SERVE: begin
                if (frame_tick_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = S_PLAY;
                        cnt_d      = '0;
                        dx_d       = 1'b1;
                        dy_d       = serve_dy_q;
                        serve_dy_d = ~serve_dy_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_PLAY: begin
                if (frame_tick_s) begin
                    if (miss_s) begin
                        state_d = S_MISS;
                    end else begin
                        dx_d     = dx_new_s;
                        dy_d     = dy_new_s;
                        ball_x_d = dx_new_s ? (ball_x_q + STEP) : (ball_x_q - STEP);
                        ball_y_d = dy_new_s ? (ball_y_q + STEP) : (ball_y_q - STEP);
                        if (hit_pad_s && (score_q != 8'hFF)) begin
                            score_d = score_q + 8'd1;
                        end else begin
                            score_d = score_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_MISS: begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d  = S_SERVE;
                    cnt_d    = '0;
                    ball_x_d = X_CENTER;
                    ball_y_d = Y_CENTER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ball_x_q    <= X_CENTER;
            ball_y_q    <= Y_CENTER;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_dy_q  <= 1'b1;
            cnt_q       <= '0;
            score_q     <= 8'd0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_dy_q  <= serve_dy_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: walks one game through serve, bounces,
// a paddle hit, three misses, game over, restart and a mid-game reset.
module tb_pong_game_ctrl;

    logic       clock = 1'b0;
    logic       rst;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic [9:0] y_pad_t;
    logic       start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_on;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;

    int n_checks = 0;
    int n_err    = 0;
    int on_count;

    pong_game_ctrl dut (
        .clock     (clock),
        .rst       (rst),
        .x_pixel   (x_pixel),
        .y_pixel   (y_pixel),
        .y_pad_t   (y_pad_t),
        .start     (start),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .ball_on   (ball_on),
        .score     (score),
        .lives     (lives),
        .game_over (game_over),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, ".x"}, {22'd0, ball_x}, ex);
        chk({tag, ".y"}, {22'd0, ball_y}, ey);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            x_pixel = 10'd0;
            y_pixel = 10'd481;
            @(posedge clock);
            #1;
            y_pixel = 10'd0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic pix(input int px, input int py);
        x_pixel = 10'(px);
        y_pixel = 10'(py);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x_pixel = 10'd0; y_pixel = 10'd0; y_pad_t = 10'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", state, 0);
        chk_pos("rst_pos", 316, 236);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_over", game_over, 0);
        pix(316, 236);
        chk("idle_hidden", ball_on, 0);
        rst = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_hold", state, 0);

        // First serve
        pulse_start();
        chk("serve_state", state, 1);
        chk("serve_score", score, 0);
        chk("serve_lives", lives, 3);
        pix(316, 236); chk("on_tl", ball_on, 1);
        pix(323, 243); chk("on_br", ball_on, 1);
        pix(324, 236); chk("on_right_out", ball_on, 0);
        pix(316, 244); chk("on_below_out", ball_on, 0);
        ticks(59);
        chk("serve_59", state, 1);
        pulse_start();
        chk("serve_start_ign", state, 1);
        ticks(1);
        chk("play_state", state, 2);
        chk_pos("play_entry", 316, 236);
        ticks(1);
        chk_pos("play_t1", 318, 238);
        pulse_start();
        chk("play_start_ign", state, 2);
        pix(325, 245); chk("play_on", ball_on, 1);
        pix(326, 245); chk("play_off", ball_on, 0);

        // Bottom bounce at y=470
        ticks(116);
        chk_pos("t117", 550, 470);
        ticks(1);
        chk_pos("bot_bounce", 552, 468);

        // Paddle hit with ball bottom exactly on paddle top
        y_pad_t = 10'd435;
        ticks(20);
        chk_pos("t138", 592, 428);
        chk("pre_hit_score", score, 0);
        ticks(1);
        chk_pos("pad_hit", 590, 426);
        chk("hit_score", score, 1);

        // Top bounce at y=2, then wall bounce at x=40
        ticks(212);
        chk_pos("t351", 166, 2);
        ticks(1);
        chk_pos("top_bounce", 164, 4);
        ticks(62);
        chk_pos("t414", 40, 128);
        ticks(1);
        chk_pos("wall_bounce", 42, 130);

        // Miss 1: paddle far away
        y_pad_t = 10'd0;
        ticks(278);
        chk_pos("t693", 598, 254);
        chk("pre_miss_state", state, 2);
        ticks(1);
        chk("miss1_state", state, 3);
        chk_pos("miss1_frozen", 598, 254);
        @(posedge clock); #1;
        chk("miss1_serve", state, 1);
        chk("miss1_lives", lives, 2);
        chk_pos("miss1_pos", 316, 236);

        // Serve 2 goes up; miss 2
        ticks(60);
        chk("serve2_play", state, 2);
        ticks(1);
        chk_pos("serve2_t1", 318, 234);
        y_pad_t = 10'd300;
        ticks(140);
        chk_pos("serve2_t141", 598, 50);
        ticks(1);
        chk("miss2_state", state, 3);
        @(posedge clock); #1;
        chk("miss2_lives", lives, 1);

        // Serve 3 goes down; miss 3 ends the game
        y_pad_t = 10'd0;
        ticks(61);
        chk_pos("serve3_t1", 318, 238);
        ticks(140);
        chk_pos("serve3_t141", 598, 422);
        ticks(1);
        chk("miss3_state", state, 3);
        @(posedge clock); #1;
        chk("over_state", state, 4);
        chk("over_flag", game_over, 1);
        chk("over_lives", lives, 0);
        chk("over_score", score, 1);
        on_count = 0;
        for (int yy = 0; yy < 480; yy++) begin
            for (int xx = 0; xx < 640; xx++) begin
                pix(xx, yy);
                if (ball_on) on_count++;
            end
        end
        chk("over_frame_dark", on_count, 0);
        ticks(5);
        chk("over_hold", state, 4);

        // Restart from OVER
        pulse_start();
        chk("restart_state", state, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_over", game_over, 0);
        chk_pos("restart_pos", 316, 236);
        ticks(61);
        chk_pos("restart_t1", 318, 238);
        y_pad_t = 10'd400;
        ticks(138);
        chk("game2_hit_score", score, 1);
        chk_pos("game2_hit", 590, 426);

        // Reset on a frame tick with start asserted, mid-game
        rst = 1'b1; start = 1'b1; x_pixel = 10'd0; y_pixel = 10'd481;
        @(posedge clock); #1;
        rst = 1'b0; start = 1'b0; y_pixel = 10'd0;
        chk("mid_rst_state", state, 0);
        chk_pos("mid_rst_pos", 316, 236);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_lives", lives, 3);
        chk("mid_rst_over", game_over, 0);
        pix(316, 236);
        chk("mid_rst_on", ball_on, 0);
        pulse_start();
        ticks(59);
        chk("mid_rst_cnt", state, 1);
        ticks(2);
        chk_pos("mid_rst_t1", 318, 238);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
